pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the VeSPA 5-stage pipeline. It drives the stall and flush inputs of the PC and the fetch/decode and decode/execute pipeline registers. It resolves memory wait, taken-branch, load-use and interrupt-entry hazards with fixed priority, and sequences multi-cycle branch flush and interrupt drain through a small FSM plus down-counter.

Parameters:
REG_ADDR_W, 5, register-index width
BRANCH_FLUSH_CYCLES, 2, cycles of fetch/decode flush after a taken branch (>=1)
IRQ_DRAIN_CYCLES, 3, NOP-injection cycles before interrupt acknowledge (>=1)

Ports:
i_Clk  in  1  clock; rising-edge logic
i_Rst  in  1  reset; asynchronous, active-high
i_DecRs1  in  REG_ADDR_W  decode-stage source reg 1
i_DecRs2  in  REG_ADDR_W  decode-stage source reg 2
i_DecUsesRs1  in  1  decode instr reads Rs1
i_DecUsesRs2  in  1  decode instr reads Rs2
i_ExRd  in  REG_ADDR_W  execute-stage destination reg
i_ExIsLoad  in  1  execute instr is a load
i_ExRegWrite  in  1  execute instr writes a register
i_MemReq  in  1  memory-stage access in progress
i_MemReady  in  1  memory access completes this cycle
i_BranchTaken  in  1  execute resolved a taken JMP/Bxx
i_IrqReq  in  1  level interrupt request
i_IrqEnable  in  1  interrupts globally enabled
o_StallPC  out  1  hold PC
o_StallFD  out  1  hold fetch/decode register
o_FlushFD  out  1  clear fetch/decode instruction
o_StallDE  out  1  hold decode/execute register
o_FlushDE  out  1  insert bubble into decode/execute
o_IrqAck  out  1  one-cycle interrupt acknowledge
o_IrqSignal  out  1  tags the fetch/decode entry as interrupt entry (one cycle)
o_State  out  3  current FSM state, debug

Behaviour:
- Reset: async; FSM to RUN, counter 0, all outputs 0 while i_Rst high. Reset mid-sequence aborts any flush/drain; no pending IRQ retained.
- Outputs are combinational from state, counter and current inputs. FSM and counter are registered.
- States (o_State): RUN=0, MEM_WAIT=1, FLUSH=2, DRAIN=3, ACK=4.
- loaduse = i_ExIsLoad & i_ExRegWrite & (i_ExRd!=0) & ((i_DecUsesRs1 & i_DecRs1==i_ExRd) | (i_DecUsesRs2 & i_DecRs2==i_ExRd)).
- memwait = i_MemReq & !i_MemReady.
- RUN, with priority memwait > branch > loaduse > irq:
  - memwait: StallPC, StallFD, StallDE = 1; next MEM_WAIT.
  - i_BranchTaken: FlushFD = FlushDE = 1. If BRANCH_FLUSH_CYCLES>1, load counter with BRANCH_FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
  - loaduse: StallPC = StallFD = FlushDE = 1 for exactly this cycle; stay in RUN. The next cycle re-evaluates, and the bubble clears the hazard.
  - i_IrqReq & i_IrqEnable: StallPC = FlushFD = 1; load counter with IRQ_DRAIN_CYCLES-1; go to DRAIN. If IRQ_DRAIN_CYCLES==1, go to ACK.
- MEM_WAIT: all three stalls = 1 while !i_MemReady. On the i_MemReady cycle, stalls = 0 and the FSM returns to RUN. Stall has priority over flush, so a branch arriving during MEM_WAIT is ignored until RUN.
- FLUSH: FlushFD = 1 each cycle while the counter decrements. At counter==0, return to RUN. A new i_BranchTaken in FLUSH reloads the counter and asserts FlushDE. Memwait in FLUSH freezes the counter and asserts all stalls; flushes are suppressed that cycle.
- DRAIN: StallPC = FlushFD = 1 and the counter decrements; at 0, go to ACK.
  - The IRQ is committed once DRAIN is entered, so i_IrqReq deasserting is ignored.
  - i_BranchTaken adds FlushDE = 1 that cycle.
  - Memwait freezes the counter, forces all stalls, and suppresses flushes.
- ACK: o_IrqAck = o_IrqSignal = 1 for one cycle, no stalls; next RUN. If memwait occurs in ACK, hold ACK with stalls asserted and Ack/IrqSignal low until ready.
- Counter width: clog2 of max(BRANCH_FLUSH_CYCLES, IRQ_DRAIN_CYCLES)+1. No wrap: it saturates at 0.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs o_StallCycles[15:0] and o_FlushEvents[15:0], both saturating at 16'hFFFF.
  - o_StallCycles counts every cycle with o_StallPC=1.
  - o_FlushEvents counts each taken-branch acceptance and each loaduse bubble.
  - Both clear on i_Rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared constants (Constants.v): state encodings, REG_ADDR_W default, BUS_MSB reuse.
- One sub-module: hazard_loaduse_detect (pure combinational compare).
- FSM and counter stay in the top module.

Test Plan:
- Load-use: ExIsLoad=1, ExRegWrite=1, ExRd=5, DecRs1=5, DecUsesRs1=1 -> one cycle of StallPC=StallFD=FlushDE=1, then 0. With ExRd=0 -> no stall.
- Branch: BranchTaken pulse in RUN, BRANCH_FLUSH_CYCLES=2 -> FlushFD=1 for 2 cycles, FlushDE=1 on the first only; o_State 0->2->0.
- Memory wait: MemReq=1, MemReady=0 for 4 cycles, then 1 -> stalls high 4 cycles, low on the ready cycle. A simultaneous BranchTaken in the first cycle produces no flush.
- IRQ: IrqReq=1, IrqEnable=1, IRQ_DRAIN_CYCLES=3 -> 3 cycles StallPC=FlushFD=1, then IrqAck=IrqSignal=1 for one cycle. Dropping IrqReq in DRAIN still yields ACK. With IrqEnable=0 -> nothing.
- Async reset: assert i_Rst mid-DRAIN between clock edges -> outputs 0 immediately, o_State=0, no later IrqAck.
- With HAZARD_PERF_CNT_EN defined: 70000 forced stall cycles -> o_StallCycles=16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the VeSPA pipeline hazard controller.
// State encodings are visible on o_State for debug.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ACK      = 3'd4
  } hz_state_t;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int BUS_MSB        = 15;
  localparam logic [BUS_MSB:0] PERF_SAT = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Saturating increment for the performance counters.
  function automatic logic [BUS_MSB:0] sat_inc(input logic [BUS_MSB:0] v);
    return (v == PERF_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_loaduse_detect.sv
// Load-use hazard detect: the decode instruction reads a register that
// the load currently in execute has not yet written back.
module hazard_loaduse_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_write,
  output logic                  loaduse
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign rd_live = ex_is_load & ex_reg_write & (ex_rd != '0);
  assign rs1_hit = dec_uses_rs1 & (dec_rs1 == ex_rd);
  assign rs2_hit = dec_uses_rs2 & (dec_rs2 == ex_rd);
  assign loaduse = rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the VeSPA 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W          = REG_ADDR_W_DEF,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int IRQ_DRAIN_CYCLES    = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [REG_ADDR_W-1:0] i_DecRs1,
  input  logic [REG_ADDR_W-1:0] i_DecRs2,
  input  logic                  i_DecUsesRs1,
  input  logic                  i_DecUsesRs2,
  input  logic [REG_ADDR_W-1:0] i_ExRd,
  input  logic                  i_ExIsLoad,
  input  logic                  i_ExRegWrite,
  input  logic                  i_MemReq,
  input  logic                  i_MemReady,
  input  logic                  i_BranchTaken,
  input  logic                  i_IrqReq,
  input  logic                  i_IrqEnable,
  output logic                  o_StallPC,
  output logic                  o_StallFD,
  output logic                  o_FlushFD,
  output logic                  o_StallDE,
  output logic                  o_FlushDE,
  output logic                  o_IrqAck,
  output logic                  o_IrqSignal,
`ifdef HAZARD_PERF_CNT_EN
  output logic [BUS_MSB:0]      o_StallCycles,
  output logic [BUS_MSB:0]      o_FlushEvents,
`endif
  output logic [2:0]            o_State
);

  localparam int CNT_MAX = max_int(BRANCH_FLUSH_CYCLES, IRQ_DRAIN_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BR_RELOAD  = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] IRQ_RELOAD = CNT_W'(IRQ_DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  hz_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_dec;

  logic loaduse;
  logic memwait;
  logic stall_pc, stall_fd, stall_de;
  logic flush_fd, flush_de;
  logic irq_ack, irq_signal;
  logic branch_accept, loaduse_bubble;

  hazard_loaduse_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_loaduse (
    .dec_rs1     (i_DecRs1),
    .dec_rs2     (i_DecRs2),
    .dec_uses_rs1(i_DecUsesRs1),
    .dec_uses_rs2(i_DecUsesRs2),
    .ex_rd       (i_ExRd),
    .ex_is_load  (i_ExIsLoad),
    .ex_reg_write(i_ExRegWrite),
    .loaduse     (loaduse)
  );

  assign memwait = i_MemReq & ~i_MemReady;
  assign cnt_dec = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    stall_pc       = 1'b0;
    stall_fd       = 1'b0;
    stall_de       = 1'b0;
    flush_fd       = 1'b0;
    flush_de       = 1'b0;
    irq_ack        = 1'b0;
    irq_signal     = 1'b0;
    branch_accept  = 1'b0;
    loaduse_bubble = 1'b0;

    // A memory wait in any state freezes everything; stalls beat flushes.
    if (memwait && state_reg != ST_RUN) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
    end

    case (state_reg)
      ST_RUN: begin
        if (memwait) begin
          stall_pc   = 1'b1;
          stall_fd   = 1'b1;
          stall_de   = 1'b1;
          state_next = ST_MEM_WAIT;
        end else if (i_BranchTaken) begin
          flush_fd      = 1'b1;
          flush_de      = 1'b1;
          branch_accept = 1'b1;
          if (BRANCH_FLUSH_CYCLES > 1) begin
            cnt_next   = BR_RELOAD;
            state_next = ST_FLUSH;
          end
        end else if (loaduse) begin
          stall_pc       = 1'b1;
          stall_fd       = 1'b1;
          flush_de       = 1'b1;
          loaduse_bubble = 1'b1;
        end else if (i_IrqReq && i_IrqEnable) begin
          stall_pc   = 1'b1;
          flush_fd   = 1'b1;
          cnt_next   = IRQ_RELOAD;
          state_next = (IRQ_DRAIN_CYCLES > 1) ? ST_DRAIN : ST_ACK;
        end
      end

      ST_MEM_WAIT: begin
        if (!memwait) begin
          state_next = ST_RUN;
        end
      end

      ST_FLUSH: begin
        if (!memwait) begin
          flush_fd = 1'b1;
          if (i_BranchTaken) begin
            flush_de      = 1'b1;
            branch_accept = 1'b1;
            cnt_next      = BR_RELOAD;
          end else begin
            cnt_next = cnt_dec;
            if (cnt_reg <= CNT_ONE) begin
              state_next = ST_RUN;
            end
          end
        end
      end

      ST_DRAIN: begin
        // The interrupt is committed here: i_IrqReq is no longer consulted.
        if (!memwait) begin
          stall_pc      = 1'b1;
          flush_fd      = 1'b1;
          flush_de      = i_BranchTaken;
          branch_accept = i_BranchTaken;
          cnt_next      = cnt_dec;
          if (cnt_reg <= CNT_ONE) begin
            state_next = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (!memwait) begin
          irq_ack    = 1'b1;
          irq_signal = 1'b1;
          state_next = ST_RUN;
        end
      end

      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are forced low for the whole time reset is held, not just after an edge.
  assign o_StallPC   = stall_pc   & ~i_Rst;
  assign o_StallFD   = stall_fd   & ~i_Rst;
  assign o_FlushFD   = flush_fd   & ~i_Rst;
  assign o_StallDE   = stall_de   & ~i_Rst;
  assign o_FlushDE   = flush_de   & ~i_Rst;
  assign o_IrqAck    = irq_ack    & ~i_Rst;
  assign o_IrqSignal = irq_signal & ~i_Rst;
  assign o_State     = state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [BUS_MSB:0] stall_cycles_reg;
  logic [BUS_MSB:0] flush_events_reg;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if (stall_pc) begin
        stall_cycles_reg <= sat_inc(stall_cycles_reg);
      end
      if (branch_accept || loaduse_bubble) begin
        flush_events_reg <= sat_inc(flush_events_reg);
      end
    end
  end

  assign o_StallCycles = stall_cycles_reg;
  assign o_FlushEvents = flush_events_reg;
`else
  logic unused_perf;
  assign unused_perf = branch_accept | loaduse_bubble;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (default parameters).
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_pipeline_hazard_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic [4:0] i_DecRs1 = '0, i_DecRs2 = '0, i_ExRd = '0;
  logic       i_DecUsesRs1 = 0, i_DecUsesRs2 = 0, i_ExIsLoad = 0, i_ExRegWrite = 0;
  logic       i_MemReq = 0, i_MemReady = 0, i_BranchTaken = 0, i_IrqReq = 0, i_IrqEnable = 0;
  logic       o_StallPC, o_StallFD, o_FlushFD, o_StallDE, o_FlushDE, o_IrqAck, o_IrqSignal;
  logic [2:0] o_State;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] o_StallCycles, o_FlushEvents;
`endif

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .BRANCH_FLUSH_CYCLES(2), .IRQ_DRAIN_CYCLES(3)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_DecRs1(i_DecRs1), .i_DecRs2(i_DecRs2),
    .i_DecUsesRs1(i_DecUsesRs1), .i_DecUsesRs2(i_DecUsesRs2),
    .i_ExRd(i_ExRd), .i_ExIsLoad(i_ExIsLoad), .i_ExRegWrite(i_ExRegWrite),
    .i_MemReq(i_MemReq), .i_MemReady(i_MemReady),
    .i_BranchTaken(i_BranchTaken), .i_IrqReq(i_IrqReq), .i_IrqEnable(i_IrqEnable),
    .o_StallPC(o_StallPC), .o_StallFD(o_StallFD), .o_FlushFD(o_FlushFD),
    .o_StallDE(o_StallDE), .o_FlushDE(o_FlushDE),
    .o_IrqAck(o_IrqAck), .o_IrqSignal(o_IrqSignal),
`ifdef HAZARD_PERF_CNT_EN
    .o_StallCycles(o_StallCycles), .o_FlushEvents(o_FlushEvents),
`endif
    .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  // Output pattern {StallPC,StallFD,FlushFD,StallDE,FlushDE,IrqAck,IrqSignal}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] BR   = 7'b0010100;
  localparam logic [6:0] FL   = 7'b0010000;
  localparam logic [6:0] MW   = 7'b1101000;
  localparam logic [6:0] IR   = 7'b1010000;
  localparam logic [6:0] IRB  = 7'b1010100;
  localparam logic [6:0] AK   = 7'b0000011;
  localparam logic [2:0] R = 3'd0, M = 3'd1, F = 3'd2, D = 3'd3, A = 3'd4;

  int n_vec = 0;
  int n_bad = 0;
  logic [6:0] outs;
  assign outs = {o_StallPC, o_StallFD, o_FlushFD, o_StallDE, o_FlushDE, o_IrqAck, o_IrqSignal};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic set_ld(input logic ld, input logic wr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    i_ExIsLoad = ld; i_ExRegWrite = wr; i_ExRd = rd;
    i_DecRs1 = r1; i_DecUsesRs1 = u1; i_DecRs2 = r2; i_DecUsesRs2 = u2;
  endtask

  // One cycle: drive, compare {state,outputs}, advance to the next falling edge.
  task automatic vec(input string tag, input logic br, input logic mreq, input logic mrdy,
                     input logic irq, input logic ien, input logic [2:0] st, input logic [6:0] ex);
    i_BranchTaken = br; i_MemReq = mreq; i_MemReady = mrdy; i_IrqReq = irq; i_IrqEnable = ien;
    #1;
    check(tag, {6'd0, o_State, outs}, {6'd0, st, ex});
    @(negedge i_Clk);
  endtask

  initial begin
    // Reset held with hazards present: outputs must stay quiet.
    i_MemReq = 1; i_BranchTaken = 1;
    @(negedge i_Clk); @(negedge i_Clk);
    #1 check("rst_hold", {6'd0, o_State, outs}, 16'd0);
    @(negedge i_Clk);
    i_Rst = 0;
    vec("idle", 0, 0, 0, 0, 0, R, NONE);

    // Load-use detection variants
    set_ld(1, 1, 5, 5, 1, 0, 0);  vec("lu_rs1",    0, 0, 0, 0, 0, R, LU);
    set_ld(0, 0, 0, 5, 1, 0, 0);  vec("lu_bubble", 0, 0, 0, 0, 0, R, NONE);
    set_ld(1, 1, 7, 3, 1, 7, 1);  vec("lu_rs2",    0, 0, 0, 0, 0, R, LU);
    set_ld(1, 1, 5, 5, 0, 5, 0);  vec("lu_nouse",  0, 0, 0, 0, 0, R, NONE);
    set_ld(1, 1, 0, 0, 1, 0, 1);  vec("lu_rd0",    0, 0, 0, 0, 0, R, NONE);
    set_ld(1, 0, 5, 5, 1, 0, 0);  vec("lu_nowr",   0, 0, 0, 0, 0, R, NONE);
    set_ld(0, 1, 5, 5, 1, 0, 0);  vec("lu_noload", 0, 0, 0, 0, 0, R, NONE);

    // Branch beats load-use; two-cycle FD flush, DE flush only first
    set_ld(1, 1, 5, 5, 1, 0, 0);  vec("br_over_lu", 1, 0, 0, 0, 0, R, BR);
    set_ld(0, 0, 0, 0, 0, 0, 0);  vec("br_flush",   0, 0, 0, 0, 0, F, FL);
    vec("br_done",  0, 0, 0, 0, 0, R, NONE);
    vec("br2_a",    1, 0, 0, 0, 0, R, BR);
    vec("br2_rel",  1, 0, 0, 0, 0, F, BR);
    vec("br2_f",    0, 0, 0, 0, 0, F, FL);
    vec("br2_end",  0, 0, 0, 0, 0, R, NONE);

    // Memory wait 4 cycles, branch in first cycle is swallowed
    vec("mw_br",    1, 1, 0, 0, 0, R, MW);
    vec("mw_1",     0, 1, 0, 0, 0, M, MW);
    vec("mw_2",     0, 1, 0, 0, 0, M, MW);
    vec("mw_3",     0, 1, 0, 0, 0, M, MW);
    vec("mw_rdy",   0, 1, 1, 0, 0, M, NONE);
    vec("mw_run",   0, 0, 0, 0, 0, R, NONE);

    // Memory wait inside FLUSH freezes the counter
    vec("fl_br",    1, 0, 0, 0, 0, R, BR);
    vec("fl_mw",    0, 1, 0, 0, 0, F, MW);
    vec("fl_res",   0, 0, 0, 0, 0, F, FL);
    vec("fl_end",   0, 0, 0, 0, 0, R, NONE);

    // Interrupt entry; request dropped during drain still acknowledged
    vec("irq_req",  0, 0, 0, 1, 1, R, IR);
    vec("irq_d1",   0, 0, 0, 0, 1, D, IR);
    vec("irq_d2",   0, 0, 0, 0, 1, D, IR);
    vec("irq_ack",  0, 0, 0, 0, 1, A, AK);
    vec("irq_run",  0, 0, 0, 0, 1, R, NONE);
    vec("irq_dis1", 0, 0, 0, 1, 0, R, NONE);
    vec("irq_dis2", 0, 0, 0, 1, 0, R, NONE);

    // Load-use beats irq; branch during drain; memwait during ack
    set_ld(1, 1, 5, 5, 1, 0, 0);  vec("lu_over_irq", 0, 0, 0, 1, 1, R, LU);
    set_ld(0, 0, 0, 0, 0, 0, 0);  vec("irq2_req",    0, 0, 0, 1, 1, R, IR);
    vec("irq2_d1",  0, 0, 0, 0, 1, D, IR);
    vec("drain_br", 1, 0, 0, 0, 1, D, IRB);
    vec("ack_mw",   0, 1, 0, 0, 1, A, MW);
    vec("ack_rdy",  0, 1, 1, 0, 1, A, AK);
    vec("ack_run",  0, 0, 0, 0, 1, R, NONE);

    // Memory wait inside DRAIN freezes the counter
    vec("irq3_req", 0, 0, 0, 1, 1, R, IR);
    vec("drain_mw", 0, 1, 0, 0, 1, D, MW);
    vec("drain_a",  0, 0, 0, 0, 1, D, IR);
    vec("drain_b",  0, 0, 0, 0, 1, D, IR);
    vec("ack3",     0, 0, 0, 0, 1, A, AK);
    vec("run3",     0, 0, 0, 0, 1, R, NONE);

    // Asynchronous reset between edges mid-drain
    vec("irq4_req", 0, 0, 0, 1, 1, R, IR);
    i_IrqReq = 0;
    #1 check("rst_pre", {6'd0, o_State, outs}, {6'd0, D, IR});
    #2 i_Rst = 1;
    #1 check("rst_async", {6'd0, o_State, outs}, 16'd0);
    @(negedge i_Clk);
    i_Rst = 0;
    vec("rst_post1", 0, 0, 0, 0, 1, R, NONE);
    vec("rst_post2", 0, 0, 0, 0, 1, R, NONE);
    vec("rst_post3", 0, 0, 0, 0, 1, R, NONE);
    vec("rst_post4", 0, 0, 0, 0, 1, R, NONE);

`ifdef HAZARD_PERF_CNT_EN
    i_Rst = 1;
    #1 check("perf_rst_stall", o_StallCycles, 16'd0);
    check("perf_rst_flush", o_FlushEvents, 16'd0);
    @(negedge i_Clk);
    i_Rst = 0;
    set_ld(1, 1, 5, 5, 1, 0, 0);  vec("perf_lu", 0, 0, 0, 0, 0, R, LU);
    set_ld(0, 0, 0, 0, 0, 0, 0);  vec("perf_br", 1, 0, 0, 0, 0, R, BR);
    vec("perf_fl",  0, 0, 0, 0, 0, F, FL);
    vec("perf_idle", 0, 0, 0, 0, 0, R, NONE);
    check("perf_flush_2", o_FlushEvents, 16'd2);
    check("perf_stall_1", o_StallCycles, 16'd1);
    i_MemReq = 1; i_MemReady = 0;
    repeat (70000) @(negedge i_Clk);
    #1 check("perf_stall_sat", o_StallCycles, 16'hFFFF);
    check("perf_flush_hold", o_FlushEvents, 16'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
